// File: rtl/kbd_event_queue.sv
`default_nettype none
// ============================================================================
// kbd_event_queue : PS/2 set-2 scan-code parser, modifier tracker and FWFT event FIFO
// Revision 1.0
// ============================================================================
module kbd_event_queue #(
  parameter int FIFO_DEPTH       = 8,
  parameter int REPORT_RELEASE   = 0,
  parameter int TYPEMATIC_FILTER = 1
) (
  input  logic                        sys_clk,
  input  logic                        reset,
  input  logic [7:0]                  scan_code,
  input  logic                        scan_code_ready,
  input  logic                        read,
  input  logic                        clr_overflow,
  output logic                        event_valid,
  output logic [7:0]                  event_code,
  output logic [7:0]                  event_ascii,
  output logic                        event_extended,
  output logic                        event_released,
  output logic [3:0]                  event_mods,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam int          EW    = 22;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GOT_E0   = 2'd1;
  localparam logic [1:0] GOT_F0   = 2'd2;
  localparam logic [1:0] GOT_E0F0 = 2'd3;

  logic [1:0] state;
  logic       ev_stb;
  logic       ev_ext;
  logic       ev_rel;
  logic [7:0] ev_code;
  logic       is_discard;

  assign is_discard = (scan_code == 8'hFA) || (scan_code == 8'hAA) || (scan_code == 8'hEE) ||
                      (scan_code == 8'hFE) || (scan_code == 8'hE1);

  // Stage 1: prefix parsing; a completed key event is registered for stage 2.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state   <= IDLE;
      ev_stb  <= 1'b0;
      ev_ext  <= 1'b0;
      ev_rel  <= 1'b0;
      ev_code <= 8'h00;
    end else begin
      ev_stb <= 1'b0;
      if (scan_code_ready) begin
        case (state)
          IDLE: begin
            if (scan_code == 8'hE0) begin
              state <= GOT_E0;
            end else if (scan_code == 8'hF0) begin
              state <= GOT_F0;
            end else if (!is_discard) begin
              ev_stb  <= 1'b1;
              ev_ext  <= 1'b0;
              ev_rel  <= 1'b0;
              ev_code <= scan_code;
            end
          end
          GOT_E0: begin
            if (scan_code == 8'hF0) begin
              state <= GOT_E0F0;
            end else begin
              ev_stb  <= 1'b1;
              ev_ext  <= 1'b1;
              ev_rel  <= 1'b0;
              ev_code <= scan_code;
              state   <= IDLE;
            end
          end
          GOT_F0: begin
            ev_stb  <= 1'b1;
            ev_ext  <= 1'b0;
            ev_rel  <= 1'b1;
            ev_code <= scan_code;
            state   <= IDLE;
          end
          default: begin
            ev_stb  <= 1'b1;
            ev_ext  <= 1'b1;
            ev_rel  <= 1'b1;
            ev_code <= scan_code;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

  logic       shift_l, shift_r, ctrl_l, ctrl_r, alt_l, alt_r;
  logic       caps_lock, caps_held;
  logic [8:0] last_make;
  logic       last_valid;
  logic       shift, ctrl, alt;
  logic       k_shift_l, k_shift_r, k_ctrl_l, k_ctrl_r, k_alt_l, k_alt_r, k_caps, k_fake;
  logic       is_mod, lm_hit, suppress, queue_it;

  assign shift = shift_l | shift_r;
  assign ctrl  = ctrl_l | ctrl_r;
  assign alt   = alt_l | alt_r;

  assign k_shift_l = !ev_ext && (ev_code == 8'h12);
  assign k_shift_r = !ev_ext && (ev_code == 8'h59);
  assign k_ctrl_l  = !ev_ext && (ev_code == 8'h14);
  assign k_ctrl_r  =  ev_ext && (ev_code == 8'h14);
  assign k_alt_l   = !ev_ext && (ev_code == 8'h11);
  assign k_alt_r   =  ev_ext && (ev_code == 8'h11);
  assign k_caps    = !ev_ext && (ev_code == 8'h58);
  assign k_fake    =  ev_ext && ((ev_code == 8'h12) || (ev_code == 8'h59));

  assign is_mod   = k_shift_l | k_shift_r | k_ctrl_l | k_ctrl_r | k_alt_l | k_alt_r | k_caps | k_fake;
  assign lm_hit   = last_valid && (last_make == {ev_ext, ev_code});
  assign suppress = (TYPEMATIC_FILTER != 0) && !ev_rel && lm_hit;
  assign queue_it = ev_stb && !is_mod && !suppress && (!ev_rel || (REPORT_RELEASE != 0));

  // Stage 2: modifier, caps-lock and typematic state.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      shift_l    <= 1'b0;
      shift_r    <= 1'b0;
      ctrl_l     <= 1'b0;
      ctrl_r     <= 1'b0;
      alt_l      <= 1'b0;
      alt_r      <= 1'b0;
      caps_lock  <= 1'b0;
      caps_held  <= 1'b0;
      last_make  <= 9'h000;
      last_valid <= 1'b0;
    end else if (ev_stb && !suppress) begin
      if (k_shift_l) shift_l <= !ev_rel;
      if (k_shift_r) shift_r <= !ev_rel;
      if (k_ctrl_l)  ctrl_l  <= !ev_rel;
      if (k_ctrl_r)  ctrl_r  <= !ev_rel;
      if (k_alt_l)   alt_l   <= !ev_rel;
      if (k_alt_r)   alt_r   <= !ev_rel;
      if (k_caps) begin
        if (!ev_rel && !caps_held) caps_lock <= !caps_lock;
        caps_held <= !ev_rel;
      end
      if (!ev_rel) begin
        last_make  <= {ev_ext, ev_code};
        last_valid <= 1'b1;
      end else if (lm_hit) begin
        last_valid <= 1'b0;
      end
    end
  end

  // {is_letter, unshifted, shifted}
  function automatic logic [16:0] us_table(input logic [7:0] code);
    case (code)
      8'h1C: return {1'b1, "a", "A"};  8'h32: return {1'b1, "b", "B"};
      8'h21: return {1'b1, "c", "C"};  8'h23: return {1'b1, "d", "D"};
      8'h24: return {1'b1, "e", "E"};  8'h2B: return {1'b1, "f", "F"};
      8'h34: return {1'b1, "g", "G"};  8'h33: return {1'b1, "h", "H"};
      8'h43: return {1'b1, "i", "I"};  8'h3B: return {1'b1, "j", "J"};
      8'h42: return {1'b1, "k", "K"};  8'h4B: return {1'b1, "l", "L"};
      8'h3A: return {1'b1, "m", "M"};  8'h31: return {1'b1, "n", "N"};
      8'h44: return {1'b1, "o", "O"};  8'h4D: return {1'b1, "p", "P"};
      8'h15: return {1'b1, "q", "Q"};  8'h2D: return {1'b1, "r", "R"};
      8'h1B: return {1'b1, "s", "S"};  8'h2C: return {1'b1, "t", "T"};
      8'h3C: return {1'b1, "u", "U"};  8'h2A: return {1'b1, "v", "V"};
      8'h1D: return {1'b1, "w", "W"};  8'h22: return {1'b1, "x", "X"};
      8'h35: return {1'b1, "y", "Y"};  8'h1A: return {1'b1, "z", "Z"};
      8'h45: return {1'b0, "0", ")"};  8'h16: return {1'b0, "1", "!"};
      8'h1E: return {1'b0, "2", "@"};  8'h26: return {1'b0, "3", "#"};
      8'h25: return {1'b0, "4", "$"};  8'h2E: return {1'b0, "5", "%"};
      8'h36: return {1'b0, "6", "^"};  8'h3D: return {1'b0, "7", "&"};
      8'h3E: return {1'b0, "8", "*"};  8'h46: return {1'b0, "9", "("};
      8'h0E: return {1'b0, 8'h60, "~"};  8'h4E: return {1'b0, "-", "_"};
      8'h55: return {1'b0, "=", "+"};  8'h5D: return {1'b0, 8'h5C, 8'h7C};
      8'h54: return {1'b0, "[", "{"};  8'h5B: return {1'b0, "]", "}"};
      8'h4C: return {1'b0, ";", ":"};  8'h52: return {1'b0, 8'h27, 8'h22};
      8'h41: return {1'b0, ",", "<"};  8'h49: return {1'b0, ".", ">"};
      8'h4A: return {1'b0, "/", "?"};  8'h29: return {1'b0, 8'h20, 8'h20};
      8'h5A: return {1'b0, 8'h0D, 8'h0D}; 8'h66: return {1'b0, 8'h08, 8'h08};
      8'h0D: return {1'b0, 8'h09, 8'h09}; 8'h76: return {1'b0, 8'h1B, 8'h1B};
      8'h71: return {1'b0, 8'h7F, 8'h7F};
      default: return {1'b0, 8'hFF, 8'hFF};
    endcase
  endfunction

  logic [16:0] tbl;
  logic [7:0]  letter;
  logic [7:0]  ascii_c;

  always_comb begin
    tbl     = us_table(ev_code);
    letter  = (shift ^ caps_lock) ? tbl[7:0] : tbl[15:8];
    ascii_c = 8'hFF;
    if (ev_ext) begin
      case (ev_code)
        8'h5A:   ascii_c = 8'h0D;
        8'h4A:   ascii_c = 8'h2F;
        8'h71:   ascii_c = 8'h7F;
        default: ascii_c = 8'hFF;
      endcase
    end else if (tbl[16]) begin
      ascii_c = ctrl ? (letter & 8'h1F) : letter;
    end else begin
      ascii_c = shift ? tbl[7:0] : tbl[15:8];
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic          full, pop, wr_ok;

  assign full  = (fifo_count == DEPTH);
  assign pop   = read && event_valid;
  assign wr_ok = queue_it && (!full || pop);

  always_ff @(posedge sys_clk) begin
    if (wr_ok) mem[wr_ptr] <= {caps_lock, alt, ctrl, shift, ev_ext, ev_rel, ascii_c, ev_code};
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // A drop in the same cycle as a clear request keeps the flag set.
      if (queue_it && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)        overflow <= 1'b0;
    end
  end

  assign head        = mem[rd_ptr];
  assign event_valid = (fifo_count != '0);
  assign {event_mods, event_extended, event_released, event_ascii, event_code} =
      event_valid ? head : '0;

endmodule
`default_nettype wire
